ftdi_uart_tx: RTL and testbench
===============================

FTDI_UART_TX -- requirements
Module: ftdi_uart_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 434, clocks per UART bit (legal range 4..65535).
REQ-002 SHALL have parameter FIFO_AW, default 4, log2 of TX FIFO depth (depth 16 at default).
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port data_in, input, 8, byte to transmit.
REQ-006 SHALL have port data_valid, input, 1, producer offers data_in this cycle.
REQ-007 SHALL have port ready, output, 1, FIFO can accept a byte this cycle.
REQ-008 SHALL have port BD1, output, 1, TXD line toward FTDI; idle level 1.
REQ-009 SHALL have port BD2, input, 1, CTS# from FTDI; 0 = host may receive; asynchronous.
REQ-010 SHALL have port busy, output, 1, FIFO non-empty or frame in progress.
REQ-011 SHALL have port fifo_level, output, FIFO_AW+1, bytes currently held in FIFO.

Function
REQ-012 SHALL accept a byte into the FIFO on each rising edge where data_valid=1 and ready=1; data_valid with ready=0 SHALL be ignored and no byte dropped silently beyond that.
REQ-013 SHALL drive ready = (fifo_level < 2^FIFO_AW), combinationally from registered count only; no dependence on data_valid.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP; frame format 8N1, LSB first.
REQ-015 IDLE: BD1=1; if FIFO non-empty and send permitted (REQ-024), SHALL pop head into shift register, clear bit counter and baud counter, go to START.
REQ-016 START: BD1=0 for exactly CLK_DIV cycles, then DATA.
REQ-017 DATA: BD1=shift[0] for CLK_DIV cycles per bit, shift right after each bit; after bit 7 go to STOP.
REQ-018 STOP: BD1=1 for CLK_DIV cycles, then IDLE; back-to-back frames SHALL have no extra idle cycle beyond the one IDLE cycle.
REQ-019 Latency: byte accepted into empty FIFO at edge N SHALL produce BD1=0 from edge N+2; frame occupies 10*CLK_DIV cycles; next frame start bit begins 1 cycle after stop bit ends.
REQ-020 Push and pop in the same cycle SHALL leave fifo_level unchanged and both operations take effect; FIFO pointers wrap modulo 2^FIFO_AW.
REQ-021 When FIFO full, a pop in that cycle SHALL NOT enable same-cycle push (ready stays 0 that cycle).
REQ-022 busy SHALL be 1 whenever fifo_level!=0 or FSM!=IDLE.
REQ-023 Baud counter SHALL be CLK_DIV-width-sufficient (16 bits) and count 0..CLK_DIV-1, wrapping to 0 at each bit boundary.

Configuration
REQ-024 With macro FTDI_CTS_FLOW_EN defined, BD2 SHALL pass a 2-flop synchronizer (reset value 1) and a frame SHALL start only when synchronized CTS#=0; without it, BD2 SHALL be ignored, no synchronizer built, start permitted whenever FIFO non-empty.
REQ-025 CTS# SHALL be evaluated only in IDLE; deassertion mid-frame SHALL NOT truncate or pause the current frame.

Reset
REQ-026 reset=1 at an edge SHALL set FSM=IDLE, BD1=1, FIFO pointers and fifo_level=0, baud/bit counters=0, CTS synchronizer flops=1, busy=0, ready=1 from the next cycle.
REQ-027 reset mid-frame SHALL abort the frame immediately (BD1=1 after the edge) and discard all queued bytes.
REQ-028 data_valid during reset SHALL be ignored.

Verification (CLK_DIV=4, FIFO_AW=2, FTDI_CTS_FLOW_EN defined unless noted)
REQ-029 BD2=0, push 0x55 at edge 10 -> BD1=0 edges 12..15, then 1,0,1,0,1,0,1,0 each 4 cycles, stop 1 for 4 cycles; busy falls at edge 52.
REQ-030 Push 0xA5 then 0x3C back-to-back -> second start bit begins exactly 41 cycles after first start bit; bits LSB-first verified.
REQ-031 BD2=1, push 6 bytes -> ready=0 after 4 accepted, 5th/6th held off, fifo_level=4, BD1 stays 1; set BD2=0 -> transmission begins within 4 cycles, ready rises after first pop.
REQ-032 Deassert BD2 mid-frame of 0xFF -> frame completes all 10 bits; next queued frame waits until BD2=0.
REQ-033 Assert reset at data bit 3 with 2 bytes queued -> BD1=1 next edge, fifo_level=0, busy=0, no further frames.
REQ-034 Macro undefined, BD2=1 held, push 0x00 -> frame transmitted normally (start + eight 0 bits + stop).

Source files
------------

// File: rtl/ftdi_uart_tx.sv
// ftdi_uart_tx: FIFO-buffered 8N1 UART transmitter toward an FTDI bridge.
// Define FTDI_CTS_FLOW_EN to gate frame starts on a synchronized CTS# (BD2).
module ftdi_uart_tx #(
  parameter int CLK_DIV = 434,
  parameter int FIFO_AW = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  output logic             ready,
  output logic             BD1,
  input  logic             BD2,
  output logic             busy,
  output logic [FIFO_AW:0] fifo_level
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL = (FIFO_AW+1)'(DEPTH);
  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q;
  logic [7:0] mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_q, rd_q;
  logic [FIFO_AW:0] cnt_q, cnt_d;
  logic [15:0] baud_q;
  logic [2:0] bit_q;
  logic [7:0] shift_q;
  logic bd1_q, frame_q, cts_ok, push, pop, tick;

`ifdef FTDI_CTS_FLOW_EN
  logic [1:0] cts_q;
  always_ff @(posedge clk)
    cts_q <= reset ? 2'b11 : {cts_q[0], BD2};
  assign cts_ok = !cts_q[1];
`else
  assign cts_ok = 1'b1 | BD2;
`endif

  assign ready = cnt_q < FULL;
  assign push = data_valid & ready;
  assign pop = (state_q == IDLE) && (cnt_q != '0) && cts_ok;
  assign tick = baud_q == DIV_M1;
  assign cnt_d = cnt_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);

  always_ff @(posedge clk)
    if (push && !reset) mem_q[wr_q] <= data_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= push ? wr_q + (FIFO_AW)'(1) : wr_q;
      rd_q <= pop ? rd_q + (FIFO_AW)'(1) : rd_q;
      cnt_q <= cnt_d;
    end
  end

  // BD1 and frame_q trail the state by one cycle, so busy covers the last stop cycle on the line
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      bd1_q <= 1'b1;
      frame_q <= 1'b0;
    end else begin
      bd1_q <= state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : 1'b1;
      frame_q <= state_q != IDLE;
      baud_q <= (state_q == IDLE || tick) ? 16'd0 : baud_q + 16'd1;
      case (state_q)
        IDLE:
          if (pop) begin
            shift_q <= mem_q[rd_q];
            bit_q <= '0;
            state_q <= START;
          end
        START:
          if (tick) state_q <= DATA;
        DATA:
          if (tick) begin
            shift_q <= shift_q >> 1;
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= STOP;
          end
        STOP:
          if (tick) state_q <= IDLE;
        default:
          state_q <= IDLE;
      endcase
    end
  end

  assign BD1 = bd1_q;
  assign busy = (cnt_q != '0) || (state_q != IDLE) || frame_q;
  assign fifo_level = cnt_q;
endmodule

// File: tb/tb_ftdi_uart_tx.sv
// tb_ftdi_uart_tx: randomized frame checks against a line-level model of 8N1 framing.
// CTS scenarios are exercised only when FTDI_CTS_FLOW_EN is defined.
module tb_ftdi_uart_tx;
  localparam int DIV = 4, AW = 2, DEPTH = 4, FRAME = 10 * DIV;
  logic clk = 1'b0, reset = 1'b1, data_valid = 1'b0, BD2 = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic ready, BD1, busy;
  logic [AW:0] fifo_level;
  int errors = 0, checks = 0, cyc = 0;

  ftdi_uart_tx #(.CLK_DIV(DIV), .FIFO_AW(AW)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .ready(ready), .BD1(BD1), .BD2(BD2), .busy(busy), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

  // Expected line bits of one frame, index 0 = start bit, 9 = stop bit
  function automatic logic [9:0] frame_of(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    data_in = b;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  task automatic wait_start(input int budget, output bit seen);
    int n = 0;
    while (BD1 !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    seen = (BD1 === 1'b0);
  endtask

  task automatic sample_frame(output logic [9:0] bits, output bit stable, output logic busy_last);
    stable = 1'b1;
    bits = 'x;
    busy_last = 1'bx;
    for (int k = 0; k < 10; k++)
      for (int j = 0; j < DIV; j++) begin
        if (j == 0) bits[k] = BD1;
        else if (BD1 !== bits[k]) stable = 1'b0;
        if (k == 9 && j == DIV - 1) busy_last = busy;
        tick();
      end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    data_valid = 1'b1;
    data_in = 8'hAA;
    repeat (3) tick();
    checks++; if (fifo_level !== 0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    checks++; if (BD1 !== 1'b1) begin errors++; $display("FAIL reset_bd1 got %b want 1", BD1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
    reset = 1'b0;
    data_valid = 1'b0;
    tick();
    checks++; if (fifo_level !== 0 || busy !== 1'b0) begin errors++; $display("FAIL post_reset got level=%0d busy=%b want 0 0", fifo_level, busy); end
  endtask

  task automatic test_frame(input logic [7:0] b);
    int tp, t0;
    bit seen, st;
    logic bl;
    logic [9:0] bits;
    push_byte(b);
    tp = cyc;
    checks++; if (fifo_level !== 1) begin errors++; $display("FAIL frame_level got %0d want 1", fifo_level); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frame_busy_push got %b want 1", busy); end
    checks++; if (BD1 !== 1'b1) begin errors++; $display("FAIL frame_idle_bd1 got %b want 1", BD1); end
    wait_start(10, seen);
    t0 = cyc;
    checks++; if (!seen || t0 - tp != 2) begin errors++; $display("FAIL frame_latency got %0d want 2 (seen=%b)", t0 - tp, seen); end
    sample_frame(bits, st, bl);
    checks++; if (bits !== frame_of(b)) begin errors++; $display("FAIL frame_bits byte %h got %b want %b", b, bits, frame_of(b)); end
    checks++; if (!st) begin errors++; $display("FAIL frame_bit_width byte %h got unstable want %0d-cycle bits", b, DIV); end
    checks++; if (bl !== 1'b1) begin errors++; $display("FAIL frame_busy_stop got %b want 1", bl); end
    checks++; if (busy !== 1'b0 || BD1 !== 1'b1) begin errors++; $display("FAIL frame_end got busy=%b bd1=%b want 0 1", busy, BD1); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v [3];
    int t [3];
    bit seen, st;
    logic bl;
    logic [9:0] bits;
    foreach (v[i]) v[i] = 8'($urandom);
    v[0] = 8'hA5;
    v[1] = 8'h3C;
    data_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = v[i];
      tick();
      checks++; if (fifo_level !== ((i == 2) ? 2 : 1)) begin errors++; $display("FAIL b2b_level%0d got %0d want %0d", i, fifo_level, (i == 2) ? 2 : 1); end
    end
    data_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_start(5, seen);
      t[i] = cyc;
      checks++; if (!seen) begin errors++; $display("FAIL b2b_start%0d got none want start", i); end
      if (i > 0) begin
        checks++; if (t[i] - t[i-1] != FRAME + 1) begin errors++; $display("FAIL b2b_gap%0d got %0d want %0d", i, t[i] - t[i-1], FRAME + 1); end
      end
      sample_frame(bits, st, bl);
      checks++; if (bits !== frame_of(v[i]) || !st) begin errors++; $display("FAIL b2b_bits%0d got %b want %b", i, bits, frame_of(v[i])); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end got %b want 0", busy); end
  endtask

`ifdef FTDI_CTS_FLOW_EN
  task automatic test_cts_hold();
    logic [7:0] q [$];
    logic [7:0] x;
    bit exp, seen, st;
    logic bl;
    logic [9:0] bits;
    int zeros = 0, trel, t0;
    BD2 = 1'b1;
    repeat (4) tick();
    data_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data_in = 8'($urandom);
      exp = q.size() < DEPTH;
      checks++; if (ready !== exp) begin errors++; $display("FAIL hold_ready%0d got %b want %b", i, ready, exp); end
      tick();
      if (exp) q.push_back(data_in);
    end
    data_valid = 1'b0;
    checks++; if (fifo_level !== DEPTH || ready !== 1'b0) begin errors++; $display("FAIL hold_full got level=%0d ready=%b want %0d 0", fifo_level, ready, DEPTH); end
    repeat (20) begin
      if (BD1 !== 1'b1) zeros++;
      tick();
    end
    checks++; if (zeros != 0) begin errors++; $display("FAIL hold_line got %0d low cycles want 0", zeros); end
    x = 8'($urandom);
    data_in = x;
    data_valid = 1'b1;
    BD2 = 1'b0;
    trel = cyc;
    while (ready !== 1'b1 && cyc - trel < 8) tick();
    checks++; if (ready !== 1'b1 || cyc - trel > 4) begin errors++; $display("FAIL hold_release got ready=%b after %0d cycles want 1 within 4", ready, cyc - trel); end
    checks++; if (fifo_level !== DEPTH - 1) begin errors++; $display("FAIL hold_pop_full got level=%0d want %0d", fifo_level, DEPTH - 1); end
    tick();
    q.push_back(x);
    data_valid = 1'b0;
    checks++; if (fifo_level !== DEPTH) begin errors++; $display("FAIL hold_refill got level=%0d want %0d", fifo_level, DEPTH); end
    wait_start(2, seen);
    t0 = cyc;
    checks++; if (!seen || t0 - trel > 4) begin errors++; $display("FAIL hold_start got %0d cycles want <=4", t0 - trel); end
    foreach (q[i]) begin
      wait_start(10, seen);
      sample_frame(bits, st, bl);
      checks++; if (!seen || bits !== frame_of(q[i]) || !st) begin errors++; $display("FAIL hold_bits%0d got %b want %b", i, bits, frame_of(q[i])); end
    end
    checks++; if (busy !== 1'b0 || fifo_level !== 0) begin errors++; $display("FAIL hold_drain got busy=%b level=%0d want 0 0", busy, fifo_level); end
  endtask

  task automatic test_cts_midframe();
    logic [7:0] r;
    bit seen, st;
    logic bl;
    logic [9:0] bits;
    int zeros = 0;
    r = 8'($urandom);
    push_byte(8'hFF);
    push_byte(r);
    wait_start(10, seen);
    BD2 = 1'b1;
    sample_frame(bits, st, bl);
    checks++; if (!seen || bits !== frame_of(8'hFF) || !st) begin errors++; $display("FAIL mid_bits got %b want %b", bits, frame_of(8'hFF)); end
    repeat (30) begin
      if (BD1 !== 1'b1) zeros++;
      tick();
    end
    checks++; if (zeros != 0 || fifo_level !== 1) begin errors++; $display("FAIL mid_wait got low=%0d level=%0d want 0 1", zeros, fifo_level); end
    BD2 = 1'b0;
    wait_start(6, seen);
    sample_frame(bits, st, bl);
    checks++; if (!seen || bits !== frame_of(r) || !st) begin errors++; $display("FAIL mid_next got %b want %b", bits, frame_of(r)); end
  endtask
`else
  task automatic test_no_cts();
    BD2 = 1'b1;
    test_frame(8'h00);
    test_frame(8'($urandom));
    BD2 = 1'b0;
  endtask
`endif

  task automatic test_reset_midframe();
    bit seen;
    int zeros = 0;
    data_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = 8'($urandom);
      tick();
    end
    data_valid = 1'b0;
    checks++; if (fifo_level !== 2) begin errors++; $display("FAIL rst_queued got %0d want 2", fifo_level); end
    wait_start(5, seen);
    repeat (DIV + 3 * DIV + 1) tick();
    data_valid = 1'b1;
    reset = 1'b1;
    tick();
    checks++; if (BD1 !== 1'b1) begin errors++; $display("FAIL rst_bd1 got %b want 1", BD1); end
    checks++; if (fifo_level !== 0 || busy !== 1'b0) begin errors++; $display("FAIL rst_flush got level=%0d busy=%b want 0 0", fifo_level, busy); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", ready); end
    reset = 1'b0;
    data_valid = 1'b0;
    repeat (60) begin
      if (BD1 !== 1'b1) zeros++;
      tick();
    end
    checks++; if (zeros != 0 || busy !== 1'b0) begin errors++; $display("FAIL rst_quiet got low=%0d busy=%b want 0 0", zeros, busy); end
  endtask

  initial begin
    test_reset();
    test_frame(8'h55);
    repeat (4) test_frame(8'($urandom));
    test_back_to_back();
`ifdef FTDI_CTS_FLOW_EN
    test_cts_hold();
    test_cts_midframe();
`else
    test_no_cts();
`endif
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
